// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: load-use stall, multi-cycle MUL hold and post-branch flush
// for the fetch/decode/execute pipeline, plus a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int unsigned MUL_LATENCY  = 3,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_uses_rs1,
    input  logic             dec_uses_rs2,
    input  logic             dec_is_load,
    input  logic             dec_is_mul,
    input  logic [4:0]       dec_rd,
    input  logic             branch_taken,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             kill_instr,
    output logic             ex_hold,
    output logic             pc_redirect,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned MCNT_W = $clog2(MUL_LATENCY + 1);
    localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MUL_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              lu_valid_q, lu_valid_d;
    logic [4:0]        lu_rd_q, lu_rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;
    logic              issue;

    assign hazard = lu_valid_q & dec_valid &
                    ((dec_uses_rs1 & (dec_rs1 == lu_rd_q)) |
                     (dec_uses_rs2 & (dec_rs2 == lu_rd_q)));
    assign issue  = dec_valid & ~stall_decode & ~kill_instr;

    // State and sequencing counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            mcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state and counter reloads
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN, LOAD_STALL: begin
                if (branch_taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == RUN && hazard) begin
                    state_d = LOAD_STALL;
                end else if (issue && dec_is_mul && MUL_LATENCY > 1) begin
                    state_d = MUL_WAIT;
                    mcnt_d  = MCNT_W'(MUL_LATENCY - 1);
                end else begin
                    state_d = RUN;
                end
            end
            MUL_WAIT: begin
                mcnt_d = mcnt_q - MCNT_W'(1);
                if (mcnt_q == MCNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (branch_taken) begin
                    fcnt_d = FCNT_W'(FLUSH_CYCLES - 1);
                    if (FLUSH_CYCLES == 1) begin
                        state_d = RUN;
                    end
                end else begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                    if (fcnt_q == FCNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Same-cycle pipeline controls; forced low while reset is held
    always_comb begin
        stall_fetch  = 1'b0;
        stall_decode = 1'b0;
        kill_instr   = 1'b0;
        ex_hold      = 1'b0;
        pc_redirect  = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        kill_instr  = 1'b1;
                        pc_redirect = 1'b1;
                    end else if (hazard) begin
                        stall_fetch  = 1'b1;
                        stall_decode = 1'b1;
                        kill_instr   = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    kill_instr  = branch_taken;
                    pc_redirect = branch_taken;
                end
                MUL_WAIT: begin
                    stall_fetch  = 1'b1;
                    stall_decode = 1'b1;
                    ex_hold      = 1'b1;
                end
                FLUSH: begin
                    kill_instr  = 1'b1;
                    pc_redirect = branch_taken;
                end
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

    // Load scoreboard tracks only the load issued on the previous edge
    always_comb begin
        lu_valid_d = issue & dec_is_load & (dec_rd != 5'd0);
        lu_rd_d    = lu_valid_d ? dec_rd : lu_rd_q;
        cnt_d      = cnt_q;
        if (stall_fetch && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_valid_q <= 1'b0;
            lu_rd_q    <= '0;
            cnt_q      <= '0;
        end else begin
            lu_valid_q <= lu_valid_d;
            lu_rd_q    <= lu_rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule
